// File: rtl/music_key_ctrl.sv
// Purpose : debounce three front-panel keys, turn presses into events, run the stop/play/pause transport and track selector.
// Latency : a key held from edge 1 acts at edge DEB_CYCLES+1; track_done acts on the edge that samples it.
// Backpress: none; keys are levels, track_done is a pulse, and outputs are registered strobes/levels that are never held off.

// Per-key debouncer. The level flips only after DEB_CYCLES consecutive disagreeing samples.
module music_key_deb #(
   parameter int DEB_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_press
);

   localparam int               CNT_W   = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_deb;
   logic             r_deb_q;

   // Count disagreeing samples; any agreeing sample (a glitch back) restarts the count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_deb   <= 1'b0;
         r_deb_q <= 1'b0;
      end else begin
         r_deb_q <= r_deb;
         if (i_raw != r_deb) begin
            if (r_cnt == CNT_MAX) begin
               r_deb <= ~r_deb;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   // Rising edge of the debounced level: one event per press, none on release.
   assign o_press = r_deb & ~r_deb_q;

endmodule

// Player control top: three debouncers, single-event arbitration, transport FSM and track selector.
module music_key_ctrl #(
   parameter int DEB_CYCLES = 4,
   parameter int NUM_TRACKS = 4,
   parameter int TRK_W      = 2
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             key_play,
   input  logic             key_next,
   input  logic             key_prev,
   input  logic             track_done,
   output logic             play_en,
   output logic [TRK_W-1:0] track_sel,
   output logic             track_load,
   output logic [1:0]       state
);

   localparam logic [1:0]       ST_STOP  = 2'b00;
   localparam logic [1:0]       ST_PLAY  = 2'b01;
   localparam logic [1:0]       ST_PAUSE = 2'b10;
   localparam logic [TRK_W-1:0] TRK_LAST = TRK_W'(NUM_TRACKS - 1);

   logic [1:0]       r_state;
   logic [TRK_W-1:0] r_sel;
   logic             r_play_en;
   logic             r_load;

   logic             w_play_evt;
   logic             w_next_evt;
   logic             w_prev_evt;
   logic             w_take_done;
   logic             w_take_play;
   logic             w_take_next;
   logic             w_take_prev;
   logic [TRK_W-1:0] w_sel_inc;
   logic [TRK_W-1:0] w_sel_dec;
   logic [1:0]       w_state_nxt;
   logic [TRK_W-1:0] w_sel_nxt;
   logic             w_load_nxt;

   music_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_play (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_raw   (key_play),
      .o_press (w_play_evt)
   );

   music_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_raw   (key_next),
      .o_press (w_next_evt)
   );

   music_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_raw   (key_prev),
      .o_press (w_prev_evt)
   );

   // Fixed-priority pick of one event per cycle; losers are simply dropped.
   always_comb begin
      w_take_done = track_done & (r_state == ST_PLAY);
      w_take_play = ~w_take_done & w_play_evt;
      w_take_next = ~w_take_done & ~w_play_evt & w_next_evt;
      w_take_prev = ~w_take_done & ~w_play_evt & ~w_next_evt & w_prev_evt;
   end

   // Modular track stepping; NUM_TRACKS need not be a power of two, so wrap explicitly.
   always_comb begin
      w_sel_inc = (r_sel == TRK_LAST) ? '0 : (r_sel + TRK_W'(1));
      w_sel_dec = (r_sel == '0) ? TRK_LAST : (r_sel - TRK_W'(1));
   end

   // Transport next-state, next track and load strobe for the selected event.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_load_nxt  = 1'b0;
      if (w_take_done) begin
         if (r_sel == TRK_LAST) begin
            // End of playlist: rewind and stop without loading.
            w_sel_nxt   = '0;
            w_state_nxt = ST_STOP;
         end else begin
            w_sel_nxt   = w_sel_inc;
            w_state_nxt = ST_PLAY;
            w_load_nxt  = 1'b1;
         end
      end else if (w_take_play) begin
         case (r_state)
            ST_STOP: begin
               w_state_nxt = ST_PLAY;
               w_load_nxt  = 1'b1;
            end
            ST_PLAY:  w_state_nxt = ST_PAUSE;
            // Resume from pause continues the current song, so no load.
            ST_PAUSE: w_state_nxt = ST_PLAY;
            default:  w_state_nxt = ST_STOP;
         endcase
      end else if (w_take_next || w_take_prev) begin
         w_sel_nxt = w_take_next ? w_sel_inc : w_sel_dec;
         // In STOP the selector moves silently; otherwise the new track starts playing.
         if (r_state != ST_STOP) begin
            w_state_nxt = ST_PLAY;
            w_load_nxt  = 1'b1;
         end
      end
      // The unused encoding falls back to STOP so it can never be presented.
      if (w_state_nxt == 2'b11) begin
         w_state_nxt = ST_STOP;
      end
   end

   // State, track and registered outputs all move on the same edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state   <= ST_STOP;
         r_sel     <= '0;
         r_play_en <= 1'b0;
         r_load    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sel     <= w_sel_nxt;
         r_play_en <= (w_state_nxt == ST_PLAY);
         r_load    <= w_load_nxt;
      end
   end

   assign state      = r_state;
   assign track_sel  = r_sel;
   assign play_en    = r_play_en;
   assign track_load = r_load;

endmodule

// File: tb/tb_music_key_ctrl.sv
// Purpose : directed scoreboard bench for music_key_ctrl (keys, transport, track wrap, reset).
// Latency : expectations carry the edge on which each output change must appear.
// Backpress: none; the monitor consumes every observed output change.
`timescale 1ns/1ps
module tb_music_key_ctrl;

   localparam int DEB = 4;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       key_play;
   logic       key_next;
   logic       key_prev;
   logic       track_done;
   logic       play_en;
   logic [1:0] track_sel;
   logic       track_load;
   logic [1:0] state;

   typedef struct {
      logic [1:0] st;
      logic [1:0] sel;
      logic       en;
      logic       ld;
      int         cyc;   // -1: any cycle (asynchronous reset)
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   passes = 0;
   bit   mon_en = 0;
   logic [4:0] prev_obs = '0;

   music_key_ctrl #(.DEB_CYCLES(DEB), .NUM_TRACKS(4), .TRK_W(2)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_play   (key_play),
      .key_next   (key_next),
      .key_prev   (key_prev),
      .track_done (track_done),
      .play_en    (play_en),
      .track_sel  (track_sel),
      .track_load (track_load),
      .state      (state)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
   endtask

   task automatic push(input logic [1:0] st, input logic [1:0] sel, input logic en, input logic ld, input int at);
      exp_t e;
      e.st = st; e.sel = sel; e.en = en; e.ld = ld; e.cyc = at;
      q.push_back(e);
   endtask

   // Monitor: any change of state/track/play_en, or any load pulse, is one observed response.
   always @(negedge sys_clk) begin
      logic [4:0] obs;
      exp_t       e;
      obs = {state, track_sel, play_en};
      if (mon_en && (obs != prev_obs || track_load)) begin
         if (q.size() == 0) begin
            check(1'b0, "unexpected_output", int'({obs, track_load}), -1);
         end else begin
            e = q.pop_front();
            check({obs, track_load} == {e.st, e.sel, e.en, e.ld}, "outputs{st,sel,en,ld}",
                  int'({obs, track_load}), int'({e.st, e.sel, e.en, e.ld}));
            if (e.cyc >= 0) check(cyc == e.cyc, "event_cycle", cyc, e.cyc);
         end
      end
      prev_obs = obs;
   end

   task automatic set_key(input int k, input logic v);
      case (k)
         0: key_play = v;
         1: key_next = v;
         default: key_prev = v;
      endcase
   endtask

   // Hold a key for 'hold' cycles from the current negedge, then release and let it settle.
   task automatic press(input int k, input int hold);
      set_key(k, 1'b1);
      repeat (hold) @(negedge sys_clk);
      set_key(k, 1'b0);
      repeat (DEB + 3) @(negedge sys_clk);
   endtask

   task automatic press_exp(input int k, input logic [1:0] st, input logic [1:0] sel, input logic en, input logic ld);
      push(st, sel, en, ld, cyc + DEB + 1);
      press(k, 6);
   endtask

   task automatic done_pulse(input bit expect_it, input logic [1:0] st, input logic [1:0] sel, input logic en, input logic ld);
      if (expect_it) push(st, sel, en, ld, cyc + 1);
      track_done = 1'b1;
      @(negedge sys_clk);
      track_done = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check(state == 2'b00, {tag, "_state"}, int'(state), 0);
      check(track_sel == 2'd0, {tag, "_track_sel"}, int'(track_sel), 0);
      check(play_en == 1'b0, {tag, "_play_en"}, int'(play_en), 0);
      check(track_load == 1'b0, {tag, "_track_load"}, int'(track_load), 0);
   endtask

   initial begin
      int r;
      sys_rst_n = 1'b0; key_play = 1'b0; key_next = 1'b0; key_prev = 1'b0; track_done = 1'b0;
      repeat (3) @(negedge sys_clk);
      check_reset_outputs("reset");
      sys_rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (20) @(negedge sys_clk);              // idle: no output may move

      press(0, DEB - 1);                           // too short: ignored
      push(2'b01, 2'd0, 1'b1, 1'b1, cyc + DEB + 1);
      press(0, 50);                                // long hold: one event at edge 5

      press_exp(0, 2'b10, 2'd0, 1'b0, 1'b0);       // pause
      press_exp(0, 2'b01, 2'd0, 1'b1, 1'b0);       // resume, no load

      done_pulse(1, 2'b01, 2'd1, 1'b1, 1'b1);      // back-to-back done pulses
      done_pulse(1, 2'b01, 2'd2, 1'b1, 1'b1);
      repeat (3) @(negedge sys_clk);
      done_pulse(1, 2'b01, 2'd3, 1'b1, 1'b1);
      repeat (3) @(negedge sys_clk);
      done_pulse(1, 2'b00, 2'd0, 1'b0, 1'b0);      // end of playlist
      repeat (3) @(negedge sys_clk);

      press_exp(2, 2'b00, 2'd3, 1'b0, 1'b0);       // prev wraps in STOP, no load
      press_exp(1, 2'b00, 2'd0, 1'b0, 1'b0);       // next wraps to 0
      done_pulse(0, 2'b00, 2'd0, 1'b0, 1'b0);      // ignored in STOP
      repeat (3) @(negedge sys_clk);
      press_exp(2, 2'b00, 2'd3, 1'b0, 1'b0);
      press_exp(0, 2'b01, 2'd3, 1'b1, 1'b1);       // play at track 3
      press_exp(1, 2'b01, 2'd0, 1'b1, 1'b1);       // next wraps with load
      press_exp(1, 2'b01, 2'd1, 1'b1, 1'b1);

      // track_done coincides with a debounced next: only done acts.
      push(2'b01, 2'd2, 1'b1, 1'b1, cyc + DEB + 1);
      key_next = 1'b1;
      repeat (DEB) @(negedge sys_clk);
      track_done = 1'b1;
      @(negedge sys_clk);
      track_done = 1'b0;
      @(negedge sys_clk);
      key_next = 1'b0;
      repeat (DEB + 3) @(negedge sys_clk);

      press_exp(2, 2'b01, 2'd1, 1'b1, 1'b1);       // prev in PLAY
      press_exp(0, 2'b10, 2'd1, 1'b0, 1'b0);       // pause
      done_pulse(0, 2'b00, 2'd0, 1'b0, 1'b0);      // ignored in PAUSE
      repeat (3) @(negedge sys_clk);
      press_exp(1, 2'b01, 2'd2, 1'b1, 1'b1);       // next from PAUSE plays

      // Asynchronous reset mid-debounce with key_next held through release.
      key_next = 1'b1;
      repeat (2) @(negedge sys_clk);
      push(2'b00, 2'd0, 1'b0, 1'b0, -1);
      #2 sys_rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      repeat (3) @(negedge sys_clk);
      r = cyc;
      push(2'b00, 2'd1, 1'b0, 1'b0, r + DEB + 1);
      sys_rst_n = 1'b1;
      repeat (DEB + 3) @(negedge sys_clk);
      key_next = 1'b0;
      repeat (DEB + 5) @(negedge sys_clk);

      check(q.size() == 0, "pending_expectations", q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
